wb_scoreboard: RTL and testbench
================================

Name: wb_scoreboard

Overview:
- Producer-side counterpart to the combinational forwarding detector.
- Records in-flight register writes at issue and retires them at writeback.
- Tells the issue stage whether the instruction it presents must stall, or can take its operand from the writeback bus in the same cycle.
- Sits between decode/issue and the writeback stage of the 4-bit-opcode pipeline.

Parameters:
- CNT_W, 2, width of per-register outstanding-write counter (max outstanding = 2^CNT_W-1)
- NREG, 32, number of architectural registers (index width fixed at 5)

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- issue_valid_i  in  1  issue stage presents an instruction
- ir_i  in  32  instruction at issue
- issue_ack_o  out  1  instruction accepted this cycle (= issue_valid_i & ~stall_o)
- stall_o  out  1  issue must hold
- fwd_o  out  2  bit0: src1 taken from writeback bus; bit1: src2 taken from writeback bus
- fwd_data1_o  out  32  forwarded src1 value (0 when fwd_o[0]=0)
- fwd_data2_o  out  32  forwarded src2 value (0 when fwd_o[1]=0)
- wb_valid_i  in  1  writeback retiring a write
- wb_reg_i  in  5  writeback destination
- wb_data_i  in  32  writeback value
- flush_i  in  1  synchronous clear of all counters
- pending_o  out  32  bit r = (cnt[r] != 0)
- wb_err_o  out  1  sticky: writeback to a register with no outstanding write

Behaviour:
- Decode, combinational on ir_i[31:28]. Unlisted sources/dest are "none"; opcodes 10-15 have no sources and no dest.
  - LW(0): dest [27:23], src1 [22:18]
  - SW(1): src1 [22:18], src2 [27:23], no dest
  - LI(2): dest only
  - ADDU(3)/MUL(6): dest [27:23], src1 [22:18], src2 [17:13]
  - ADDIU(4)/SLL(5)/MULI(9): dest [27:23], src1 [22:18]
  - BGE(7): src1 [27:23], src2 [22:18], no dest
  - J(8): nothing
- r0 is treated like every other register; no zero special case.
- State: cnt[r], CNT_W bits per register; wb_err flop.
- Reset (async, rst_n_i=0): all cnt=0, wb_err=0.
  - Consequently pending_o=0, stall_o=0, fwd_o=0, fwd data=0, issue_ack_o=issue_valid_i.
- Per source s (combinational), with wb_hit_s = wb_valid_i & wb_reg_i==s:
  - cnt[s]==0: no hazard, fwd bit 0.
  - cnt[s]==1 & wb_hit_s: fwd bit 1, fwd data = wb_data_i, no stall.
  - Otherwise cnt[s]!=0: hazard.
- Full: the instruction has a dest d and cnt[d] is all-ones, with no wb_hit on d this cycle.
- stall_o = issue_valid_i & (any source hazard | full). stall_o and fwd_o are 0 when issue_valid_i=0.
- Clock-edge update per register r:
  - inc = issue_ack_o & instruction has dest r
  - dec = wb_valid_i & wb_reg_i==r & cnt[r]!=0
  - cnt[r] += inc - dec; inc and dec together leave cnt unchanged.
- Wrap-around: full blocks any increment past all-ones. dec at 0 is suppressed, so there is no underflow.
- wb_err: set on wb_valid_i & cnt[wb_reg_i]==0 (evaluated before same-edge inc). Cleared only by reset.
- flush_i=1:
  - All cnt=0 next edge; the issue in that cycle is not recorded.
  - fwd/stall outputs still computed combinationally that cycle.
  - wb_err is unaffected.
- Latency: an issue recorded at edge N is visible to stall_o in cycle N+1. A writeback at edge N frees the register in cycle N+1, and is forwarded in-cycle when it is the last outstanding write.
- Self-dependence (source == dest, e.g. ADDU r5,r5,r1): hazard check uses cnt before the increment.

Test Plan:
1. Reset mid-operation: issue 0x3284_4000 (ADDU r5,r1,r2), pulse rst_n_i=0 asynchronously -> pending_o=0 immediately; stall_o=0, wb_err_o=0.
2. Issue 0x3284_4000, next cycle present 0x3314_0000 (ADDU r6,r5,r0) with no wb -> stall_o=1, issue_ack_o=0. Same ir with wb_valid_i=1, wb_reg_i=5, wb_data_i=0xDEAD_BEEF -> stall_o=0, fwd_o=2'b01, fwd_data1_o=0xDEAD_BEEF; next cycle pending_o=0x0000_0040.
3. r5 outstanding once, present SW 0x1284_0000 with wb to r5 (data 0x1234) -> fwd_o=2'b10, fwd_data2_o=0x1234, fwd_data1_o=0.
4. Issue LI r7 three times -> cnt[r7]=3. Fourth LI r7 -> stall_o=1 (full). Same cycle add wb r7 -> accepted, cnt stays 3. Two wbs without issue -> cnt=1.
5. Issue ADDU r3 with simultaneous wb r3 while cnt[r3]=1 -> cnt[r3] still 1, pending_o[3]=1, wb_err_o=0.
6. wb r9 with cnt[r9]=0 -> wb_err_o=1 next cycle and stays 1. flush_i=1 -> pending_o=0, wb_err_o still 1.

Source files
------------

// File: rtl/wb_scoreboard.sv
// Per-register outstanding-write scoreboard between issue and writeback.
// It stalls issue on hazards and forwards from writeback when only one write is outstanding.
module wb_scoreboard #(
  parameter int CNT_W = 2,
  parameter int NREG  = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        issue_valid_i,
  input  logic [31:0] ir_i,
  output logic        issue_ack_o,
  output logic        stall_o,
  output logic [1:0]  fwd_o,
  output logic [31:0] fwd_data1_o,
  output logic [31:0] fwd_data2_o,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_reg_i,
  input  logic [31:0] wb_data_i,
  input  logic        flush_i,
  output logic [31:0] pending_o,
  output logic        wb_err_o
);

  typedef enum logic [3:0] {
    OP_LW, OP_SW, OP_LI, OP_ADDU, OP_ADDIU, OP_SLL, OP_MUL, OP_BGE, OP_J, OP_MULI
  } op_e;

  typedef struct packed {
    logic       has_dst;
    logic [4:0] dst;
    logic       has_s1;
    logic [4:0] s1;
    logic       has_s2;
    logic [4:0] s2;
  } dec_t;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             wb_err_q;
  dec_t             dec;
  logic [CNT_W-1:0] cnt_s1, cnt_s2;
  logic             hit1, hit2, haz1, haz2, full;
  logic             unused_ir;

  assign unused_ir = ^ir_i[12:0];

  // NOTE: every field gets a default first so no path through the case leaves a latch.
  always_comb begin
    dec = '0;
    unique case (op_e'(ir_i[31:28]))
      OP_LW, OP_ADDIU, OP_SLL, OP_MULI: begin
        dec.has_dst = 1'b1; dec.dst = ir_i[27:23];
        dec.has_s1  = 1'b1; dec.s1  = ir_i[22:18];
      end
      OP_SW: begin
        dec.has_s1 = 1'b1; dec.s1 = ir_i[22:18];
        dec.has_s2 = 1'b1; dec.s2 = ir_i[27:23];
      end
      OP_LI: begin
        dec.has_dst = 1'b1; dec.dst = ir_i[27:23];
      end
      OP_ADDU, OP_MUL: begin
        dec.has_dst = 1'b1; dec.dst = ir_i[27:23];
        dec.has_s1  = 1'b1; dec.s1  = ir_i[22:18];
        dec.has_s2  = 1'b1; dec.s2  = ir_i[17:13];
      end
      OP_BGE: begin
        dec.has_s1 = 1'b1; dec.s1 = ir_i[27:23];
        dec.has_s2 = 1'b1; dec.s2 = ir_i[22:18];
      end
      default: dec = '0;
    endcase
  end

  // Hazard checks use the pre-increment count, so self-dependence sees older writes only.
  always_comb begin
    cnt_s1 = cnt_q[dec.s1];
    cnt_s2 = cnt_q[dec.s2];
    hit1   = wb_valid_i && (wb_reg_i == dec.s1);
    hit2   = wb_valid_i && (wb_reg_i == dec.s2);
    haz1   = dec.has_s1 && (cnt_s1 != '0) && !((cnt_s1 == CNT_W'(1)) && hit1);
    haz2   = dec.has_s2 && (cnt_s2 != '0) && !((cnt_s2 == CNT_W'(1)) && hit2);
    full   = dec.has_dst && (cnt_q[dec.dst] == '1)
             && !(wb_valid_i && (wb_reg_i == dec.dst));
  end

  always_comb begin
    fwd_o[0]    = issue_valid_i && dec.has_s1 && (cnt_s1 == CNT_W'(1)) && hit1;
    fwd_o[1]    = issue_valid_i && dec.has_s2 && (cnt_s2 == CNT_W'(1)) && hit2;
    fwd_data1_o = fwd_o[0] ? wb_data_i : 32'h0;
    fwd_data2_o = fwd_o[1] ? wb_data_i : 32'h0;
    stall_o     = issue_valid_i && (haz1 || haz2 || full);
    issue_ack_o = issue_valid_i && !stall_o;
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      logic inc, dec_r;
      inc   = issue_ack_o && dec.has_dst && (dec.dst == 5'(r));
      dec_r = wb_valid_i && (wb_reg_i == 5'(r)) && (cnt_q[r] != '0);
      cnt_d[r] = cnt_q[r];
      if (inc && !dec_r)      cnt_d[r] = cnt_q[r] + CNT_W'(1);
      else if (dec_r && !inc) cnt_d[r] = cnt_q[r] - CNT_W'(1);
    end
  end

  always_comb begin
    pending_o = '0;
    for (int r = 0; r < NREG; r++) pending_o[r] = (cnt_q[r] != '0);
  end

  assign wb_err_o = wb_err_q;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      wb_err_q <= 1'b0;
    end else begin
      if (wb_valid_i && (cnt_q[wb_reg_i] == '0)) wb_err_q <= 1'b1;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= flush_i ? '0 : cnt_d[r];
    end
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Directed bench for wb_scoreboard: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares them against the DUT.
module tb_wb_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        issue_valid_i;
  logic [31:0] ir_i;
  logic        issue_ack_o, stall_o;
  logic [1:0]  fwd_o;
  logic [31:0] fwd_data1_o, fwd_data2_o;
  logic        wb_valid_i;
  logic [4:0]  wb_reg_i;
  logic [31:0] wb_data_i;
  logic        flush_i;
  logic [31:0] pending_o;
  logic        wb_err_o;

  always #5 clk_i = ~clk_i;

  wb_scoreboard #(.CNT_W(2), .NREG(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .issue_valid_i(issue_valid_i), .ir_i(ir_i),
    .issue_ack_o(issue_ack_o), .stall_o(stall_o), .fwd_o(fwd_o),
    .fwd_data1_o(fwd_data1_o), .fwd_data2_o(fwd_data2_o),
    .wb_valid_i(wb_valid_i), .wb_reg_i(wb_reg_i), .wb_data_i(wb_data_i),
    .flush_i(flush_i), .pending_o(pending_o), .wb_err_o(wb_err_o)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic        ack;
    logic [1:0]  fwd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] pend;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  localparam logic [31:0] ADDU_5_1_2 = 32'h3284_4000;
  localparam logic [31:0] ADDU_6_5_0 = 32'h3314_0000;
  localparam logic [31:0] LI_5       = 32'h2280_0000;
  localparam logic [31:0] SW_1_5     = 32'h1284_0000;
  localparam logic [31:0] LI_7       = 32'h2380_0000;
  localparam logic [31:0] ADDU_3_7_0 = 32'h319C_0000;
  localparam logic [31:0] ADDU_3_0_0 = 32'h3180_0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.name, ".stall"},   32'(stall_o),     32'(e.stall));
      check({e.name, ".ack"},     32'(issue_ack_o), 32'(e.ack));
      check({e.name, ".fwd"},     32'(fwd_o),       32'(e.fwd));
      check({e.name, ".fdata1"},  fwd_data1_o,      e.d1);
      check({e.name, ".fdata2"},  fwd_data2_o,      e.d2);
      check({e.name, ".pending"}, pending_o,        e.pend);
      check({e.name, ".wb_err"},  32'(wb_err_o),    32'(e.err));
    end
  end

  task automatic drive(input logic v, input logic [31:0] ir, input logic wv,
                       input logic [4:0] wr, input logic [31:0] wd, input logic fl);
    @(posedge clk_i);
    #1;
    issue_valid_i = v;
    ir_i          = ir;
    wb_valid_i    = wv;
    wb_reg_i      = wr;
    wb_data_i     = wd;
    flush_i       = fl;
  endtask

  task automatic expect_o(input string name, input logic stall, input logic ack,
                          input logic [1:0] fwd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] pend, input logic err);
    exp_t e;
    e.name = name; e.stall = stall; e.ack = ack; e.fwd = fwd;
    e.d1 = d1; e.d2 = d2; e.pend = pend; e.err = err;
    sb_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i = 1'b0; issue_valid_i = 1'b0; ir_i = '0;
    wb_valid_i = 1'b0; wb_reg_i = '0; wb_data_i = '0; flush_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #3 rst_n_i = 1'b1;

    // Reset in the middle of an outstanding write.
    drive(1, ADDU_5_1_2, 0, 0, 0, 0); expect_o("t1_issue", 0, 1, 2'b00, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 0, 0);          expect_o("t1_pend",  0, 0, 2'b00, 0, 0, 32'h20, 0);
    @(negedge clk_i); #1;
    rst_n_i = 1'b0; #1;
    expect_o("t1_rst", 0, 0, 2'b00, 0, 0, 32'h0, 0);
    @(negedge clk_i); #2;
    rst_n_i = 1'b1;

    // RAW stall, then in-cycle forwarding of the last outstanding write.
    drive(1, ADDU_5_1_2, 0, 0, 0, 0);            expect_o("t2_issue", 0, 1, 2'b00, 0, 0, 32'h0, 0);
    drive(1, ADDU_6_5_0, 0, 0, 0, 0);            expect_o("t2_stall", 1, 0, 2'b00, 0, 0, 32'h20, 0);
    drive(1, ADDU_6_5_0, 1, 5, 32'hDEAD_BEEF, 0); expect_o("t2_fwd", 0, 1, 2'b01, 32'hDEAD_BEEF, 0, 32'h20, 0);
    drive(0, 0, 0, 0, 0, 0);                     expect_o("t2_after", 0, 0, 2'b00, 0, 0, 32'h40, 0);

    // SW takes src2 from [27:23]; forward lands on fwd bit 1.
    drive(1, LI_5, 0, 0, 0, 0);                  expect_o("t3_li5", 0, 1, 2'b00, 0, 0, 32'h40, 0);
    drive(1, SW_1_5, 1, 5, 32'h1234, 0);         expect_o("t3_sw", 0, 1, 2'b10, 0, 32'h1234, 32'h60, 0);

    // Counter saturation: full blocks a fourth issue unless a writeback frees a slot.
    drive(1, LI_7, 0, 0, 0, 0);                  expect_o("t4_li_a", 0, 1, 2'b00, 0, 0, 32'h40, 0);
    drive(1, LI_7, 0, 0, 0, 0);                  expect_o("t4_li_b", 0, 1, 2'b00, 0, 0, 32'hC0, 0);
    drive(1, LI_7, 0, 0, 0, 0);                  expect_o("t4_li_c", 0, 1, 2'b00, 0, 0, 32'hC0, 0);
    drive(1, LI_7, 0, 0, 0, 0);                  expect_o("t4_full", 1, 0, 2'b00, 0, 0, 32'hC0, 0);
    drive(1, LI_7, 1, 7, 32'h55, 0);             expect_o("t4_full_wb", 0, 1, 2'b00, 0, 0, 32'hC0, 0);
    drive(0, 0, 1, 7, 0, 0);                     expect_o("t4_wb1", 0, 0, 2'b00, 0, 0, 32'hC0, 0);
    drive(0, 0, 1, 7, 0, 0);                     expect_o("t4_wb2", 0, 0, 2'b00, 0, 0, 32'hC0, 0);
    // Forwarding here proves cnt[r7] is exactly 1.
    drive(1, ADDU_3_7_0, 1, 7, 32'hA5A5_A5A5, 0); expect_o("t4_cnt1", 0, 1, 2'b01, 32'hA5A5_A5A5, 0, 32'hC0, 0);

    // Simultaneous issue and writeback to the same register leaves the count unchanged.
    drive(1, ADDU_3_0_0, 1, 3, 32'h77, 0);       expect_o("t5_incdec", 0, 1, 2'b00, 0, 0, 32'h48, 0);
    drive(0, 0, 0, 0, 0, 0);                     expect_o("t5_after", 0, 0, 2'b00, 0, 0, 32'h48, 0);

    // Spurious writeback sets the sticky error; flush drops the issue and clears counts only.
    drive(0, 0, 1, 9, 32'h9, 0);                 expect_o("t6_wb9", 0, 0, 2'b00, 0, 0, 32'h48, 0);
    drive(0, 0, 0, 0, 0, 0);                     expect_o("t6_err", 0, 0, 2'b00, 0, 0, 32'h48, 1);
    drive(1, LI_7, 0, 0, 0, 1);                  expect_o("t6_flush", 0, 1, 2'b00, 0, 0, 32'h48, 1);
    drive(0, 0, 0, 0, 0, 0);                     expect_o("t6_post", 0, 0, 2'b00, 0, 0, 32'h0, 1);

    @(negedge clk_i); #1;
    if (sb_q.size() != 0) check("queue_drained", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
